// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset controller: state encoding and counter sizing.
package pll_rst_pkg;

   // Reset sequencing states
   typedef enum logic [1:0] {
      StWaitLock = 2'd0,
      StDebounce = 2'd1,
      StHold     = 2'd2,
      StRun      = 2'd3
   } state_e;

   // Width of the shared phase counter: enough to hold max(deb, hold) - 1, at least 1 bit
   function automatic int unsigned cnt_width(input int unsigned deb, input int unsigned hold);
      int unsigned m;
      m = (deb > hold) ? deb : hold;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage synchronizer for a single asynchronous input, async active-low reset to 0.
module sync_ff #(
   parameter int unsigned Stages = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [Stages-1:0] sync_q;

   // Shift the input through the flop chain
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[Stages-2:0], d_i};
      end
   end

   assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// Sequences the SoC reset from the PLL lock flag: synchronize, debounce, hold, run.
module pll_reset_ctrl
   import pll_rst_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1024,
   parameter int unsigned HOLD_CYCLES     = 16,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             locked,
   input  logic             sw_rst_req,
   input  logic             clr_sticky,
   output logic             soc_resetn,
   output logic             ready,
   output logic             lock_lost,
   output logic [CNT_W-1:0] lost_cnt
);

   localparam int unsigned     CntW     = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
   localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);

   logic             lock_s;
   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             soc_resetn_q;
   logic             lock_lost_q, lock_lost_d;
   logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;

   sync_ff #(
      .Stages (SYNC_STAGES)
   ) u_sync_locked (
      .clk_i  (clk),
      .rst_ni (resetn),
      .d_i    (locked),
      .q_o    (lock_s)
   );

   // Next-state, phase counter and lock-loss bookkeeping
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lock_lost_d = lock_lost_q;
      lost_cnt_d  = lost_cnt_q;
      // Clear first so a coincident loss event below overrides it
      if (clr_sticky) begin
         lock_lost_d = 1'b0;
      end
      unique case (state_q)
         StWaitLock: begin
            cnt_d = '0;
            if (lock_s) begin
               state_d = StDebounce;
            end
         end
         StDebounce: begin
            if (!lock_s) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (cnt_q == DebLast) begin
               state_d = StHold;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StHold: begin
            if (!lock_s) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (cnt_q == HoldLast) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRun: begin
            cnt_d = '0;
            if (!lock_s) begin
               state_d     = StWaitLock;
               lock_lost_d = 1'b1;
               if (lost_cnt_q != '1) begin
                  lost_cnt_d = lost_cnt_q + 1'b1;
               end
            end else if (sw_rst_req) begin
               // Software reset skips debounce: lock is known good
               state_d = StHold;
            end
         end
         default: begin
            state_d = StWaitLock;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers; soc_resetn follows the state being entered
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StWaitLock;
         cnt_q        <= '0;
         soc_resetn_q <= 1'b0;
         lock_lost_q  <= 1'b0;
         lost_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         soc_resetn_q <= (state_d == StRun);
         lock_lost_q  <= lock_lost_d;
         lost_cnt_q   <= lost_cnt_d;
      end
   end

   assign soc_resetn = soc_resetn_q;
   assign ready      = soc_resetn_q;
   assign lock_lost  = lock_lost_q;
   assign lost_cnt   = lost_cnt_q;

endmodule
